alu_multicycle: RTL
===================

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 SHALL have parameter WIDTH, default 8, datapath width in bits (legal range 2..32).
REQ-002 SHALL have parameter CNT_W, default $clog2(WIDTH)+1, width of the shift counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  the operation on op/a/b is valid.
REQ-006 SHALL have port in_ready  output  1  the block can accept an operation.
REQ-007 SHALL have port op  input  3  encoding: ADD=000, SUB=001, SLL=010, SRL=011, EQU=100, GTR=101, AND=110, XOR=111.
REQ-008 SHALL have port a  input  WIDTH  first operand; also the shift source.
REQ-009 SHALL have port b  input  WIDTH  second operand; also the shift amount (unsigned).
REQ-010 SHALL have port out_valid  output  1  result/flags are valid.
REQ-011 SHALL have port out_ready  input  1  the consumer takes the result.
REQ-012 SHALL have port result  output  WIDTH  registered result.
REQ-013 SHALL have port carry  output  1  ADD carry-out; SUB borrow (a<b unsigned); 0 for all other ops.
REQ-014 SHALL have port zero  output  1  result == 0.
REQ-015 SHALL have port busy  output  1  high while in SHIFT state.

Function
REQ-016 SHALL implement an FSM with states IDLE, SHIFT and DONE.
REQ-017 in_ready SHALL be 1 only in IDLE with reset low; an accept is in_valid && in_ready on a clock edge.
REQ-018 op, a and b SHALL be sampled only on accept; input changes at any other time SHALL be ignored.
REQ-019 On accepting a non-shift op: result, carry and zero SHALL be registered on the same edge, and IDLE->DONE (out_valid high the cycle after accept, latency 1).
REQ-020 ADD/SUB SHALL be modulo 2^WIDTH; carry per REQ-013.
REQ-021 EQU SHALL give result = 1 if a==b, else 0; GTR SHALL give result = 1 if a>b (unsigned), else 0; upper bits are 0.
REQ-022 AND and XOR SHALL be bitwise.
REQ-023 On accepting SLL/SRL: the work register SHALL load a, and count SHALL load N = min(b, WIDTH).
REQ-024 If N==0: IDLE->DONE, with result = a and latency 1.
REQ-025 If N>0: IDLE->SHIFT; in each SHIFT cycle the work register SHALL shift by one bit (zero fill) and count SHALL decrement.
REQ-026 SHIFT->DONE SHALL occur on the edge where count reaches 0; out_valid SHALL rise N+1 cycles after the accept edge.
REQ-027 b >= WIDTH SHALL yield result 0 after WIDTH shift cycles.
REQ-028 For shifts, carry SHALL be 0 and zero SHALL be computed from the final result.
REQ-029 In DONE: out_valid=1, and result/carry/zero SHALL be held stable until out_ready is high on an edge; then DONE->IDLE.
REQ-030 A new operation SHALL not be accepted in DONE or SHIFT, even if out_ready is high in the same cycle; maximum throughput is one op per 2 cycles.
REQ-031 busy SHALL be 1 exactly in SHIFT; out_valid SHALL be 1 exactly in DONE.

Reset
REQ-032 While reset is high on an edge: state SHALL go to IDLE; result, carry, zero, count and the work register SHALL go to 0.
REQ-033 While reset is high: out_valid, busy and in_ready SHALL be 0.
REQ-034 Reset during SHIFT or DONE SHALL abort the operation with no result delivered; reset SHALL take priority over accept and over out_ready.
REQ-035 in_ready SHALL be 1 in the first cycle after reset deasserts.

Verification (WIDTH=8)
REQ-036 ADD a=0xF0, b=0x20 -> out_valid the cycle after accept; result=0x10, carry=1, zero=0.
REQ-037 SUB a=0x05, b=0x05 -> result=0x00, zero=1, carry=0; SUB a=0x03, b=0x04 -> result=0xFF, carry=1.
REQ-038 SLL a=0x81, b=3 -> busy for 3 cycles, out_valid 4 cycles after accept, result=0x08; SRL a=0x81, b=9 -> out_valid 9 cycles after accept, result=0x00, zero=1.
REQ-039 Backpressure: XOR a=0xAA, b=0xFF with out_ready low for 5 cycles -> result=0x55 held stable; in_ready=0 and in_valid pulses ignored; out_ready high -> IDLE next cycle.
REQ-040 Reset asserted mid-SHIFT (SLL b=6, reset on the 3rd shift cycle) -> next cycle all outputs 0, in_ready=1 after deassert, and no out_valid for the aborted op.
REQ-041 EQU a=b=0x3C -> result=0x01; GTR a=0x80, b=0x7F -> result=0x01; GTR a=0x7F, b=0x80 -> result=0x00, zero=1.

Source files
------------

// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - multicycle ALU with a one-bit-per-cycle shifter and valid/ready handshake
module alu_multicycle #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             busy
);
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_SLL = 3'b010;
    localparam logic [2:0] OP_SRL = 3'b011;
    localparam logic [2:0] OP_EQU = 3'b100;
    localparam logic [2:0] OP_GTR = 3'b101;
    localparam logic [2:0] OP_AND = 3'b110;
    localparam logic [2:0] OP_XOR = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] work, work_sh, alu_res;
    logic [CNT_W-1:0] count, shift_n;
    logic             shift_left, alu_carry, accept, is_shift;

    // Handshake outputs are forced low while reset is asserted, not just after it.
    assign in_ready  = (state == IDLE)  && !reset;
    assign out_valid = (state == DONE)  && !reset;
    assign busy      = (state == SHIFT) && !reset;
    assign accept    = in_valid && in_ready;
    assign is_shift  = (op == OP_SLL) || (op == OP_SRL);
    assign shift_n   = (32'(b) >= 32'(WIDTH)) ? CNT_W'(WIDTH) : CNT_W'(b);
    assign work_sh   = shift_left ? (work << 1) : (work >> 1);

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        case (op)
            OP_ADD: {alu_carry, alu_res} = {1'b0, a} + {1'b0, b};
            OP_SUB: begin
                alu_res   = a - b;
                alu_carry = (a < b);
            end
            OP_EQU: alu_res = {{(WIDTH-1){1'b0}}, (a == b)};
            OP_GTR: alu_res = {{(WIDTH-1){1'b0}}, (a > b)};
            OP_AND: alu_res = a & b;
            OP_XOR: alu_res = a ^ b;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (is_shift && (shift_n != '0)) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (count == CNT_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            result     <= '0;
            carry      <= 1'b0;
            zero       <= 1'b0;
            count      <= '0;
            work       <= '0;
            shift_left <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_shift) begin
                            work       <= a;
                            count      <= shift_n;
                            shift_left <= (op == OP_SLL);
                            carry      <= 1'b0;
                            // A zero-length shift completes immediately with the source unchanged.
                            if (shift_n == '0) begin
                                result <= a;
                                zero   <= (a == '0);
                            end
                        end else begin
                            result <= alu_res;
                            carry  <= alu_carry;
                            zero   <= (alu_res == '0);
                        end
                    end
                end
                SHIFT: begin
                    work  <= work_sh;
                    count <= count - CNT_W'(1);
                    if (count == CNT_W'(1)) begin
                        result <= work_sh;
                        zero   <= (work_sh == '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule
